// File: rtl/reg_file_mp.sv
// Multi-port register file: byte-lane write, zero register, write-to-read bypass.
// Read latency 0 (RD_REG=0) or 1 edge (RD_REG=1); always ready, no backpressure.
module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int RD_REG   = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr,
    input  logic [DATA_W/8-1:0]        wbe,
    input  logic [ADDR_W-1:0]          addr3,
    input  logic [DATA_W-1:0]          data3,
    input  logic [NUM_RD*ADDR_W-1:0]   addr,
    output logic [NUM_RD*DATA_W-1:0]   rdout
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int NB    = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] wdat_d;
    logic              wr_commit;
    logic [DATA_W-1:0] rd_v   [NUM_RD];
    logic [DATA_W-1:0] rd_src [NUM_RD];

    // Entry 0 is never written when it is the hard-wired zero register.
    assign wr_commit = rst_n && wr && (|wbe) &&
                       !((ZERO_REG != 0) && (addr3 == '0));

    always_comb begin
        wdat_d = mem_q[addr3];
        for (int i = 0; i < NB; i++) begin
            if (wbe[i]) begin
                wdat_d[8*i +: 8] = data3[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int e = 0; e < DEPTH; e++) begin
                mem_q[e] <= '0;
            end
        end else if (wr_commit) begin
            mem_q[addr3] <= wdat_d;
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_RD; k++) begin
            rd_v[k] = mem_q[addr[k*ADDR_W +: ADDR_W]];
            if ((ZERO_REG != 0) && (addr[k*ADDR_W +: ADDR_W] == '0)) begin
                rd_v[k] = '0;
            end else if ((BYPASS != 0) && wr_commit &&
                         (addr[k*ADDR_W +: ADDR_W] == addr3)) begin
                rd_v[k] = wdat_d;
            end
        end
    end

    generate
        if (RD_REG != 0) begin : g_rd_reg
            logic [DATA_W-1:0] rdout_q [NUM_RD];

            always_ff @(posedge clk) begin
                for (int k = 0; k < NUM_RD; k++) begin
                    if (!rst_n) begin
                        rdout_q[k] <= '0;
                    end else begin
                        rdout_q[k] <= rd_v[k];
                    end
                end
            end

            always_comb begin
                for (int k = 0; k < NUM_RD; k++) begin
                    rd_src[k] = rdout_q[k];
                end
            end
        end else begin : g_rd_comb
            always_comb begin
                for (int k = 0; k < NUM_RD; k++) begin
                    rd_src[k] = rd_v[k];
                end
            end
        end
    endgenerate

    // Outputs are forced to zero for the whole time reset is held.
    always_comb begin
        rdout = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rdout[k*DATA_W +: DATA_W] = rst_n ? rd_src[k] : '0;
        end
    end

endmodule
